timer_countdown: RTL and testbench
==================================

// Module: timer_countdown
// PURPOSE
//  BCD MM:SS countdown core of the kitchen timer. Loads a set time, counts down
//  once per second, and raises an alarm at 00:00. Sits directly upstream of the
//  seven-segment digit scanner: bin0..bin3 feed its four digit inputs unchanged.
//  Timebase is derived internally from the 1 kHz system clock.
// PARAMETERS
//  TICK_DIV    1000  clk cycles per one-second tick (bench uses 4)
//  ALARM_SECS  10    ticks before alarm self-clears (only with ALARM_TIMEOUT_EN)
// PORTS
//  clk      in   1  system clock, 1 kHz, rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  load     in   1  1-cycle pulse: capture set0..set3 (IDLE only)
//  start    in   1  1-cycle pulse: begin/resume countdown
//  stop     in   1  1-cycle pulse: pause countdown
//  clear    in   1  1-cycle pulse: abort, zero digits, go IDLE
//  set0..3  in   4  BCD set value: sec ones, sec tens, min ones, min tens
//  bin0..3  out  4  current BCD digits, same ordering as set0..3
//  running  out  1  high in RUN
//  alarm    out  1  high in ALARM
// BEHAVIOUR
//  Reset: state=IDLE, bin0..bin3=0, running=0, alarm=0, prescaler=0.
//  States: IDLE, RUN, PAUSE, ALARM; all outputs registered.
//  Command priority in one cycle: clear > load > stop > start.
//  IDLE : load -> digits<=set (next cycle). start with digits!=00:00 -> RUN,
//         prescaler<=0. start at 00:00 ignored. stop ignored.
//  RUN  : prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 a tick decrements time.
//         First tick lands TICK_DIV cycles after start accepted. stop -> PAUSE,
//         prescaler held. load and start ignored.
//  PAUSE: start -> RUN, prescaler resumes from held value. load ignored.
//  clear: any state -> IDLE, digits<=0, prescaler<=0, next cycle.
//  Decrement: bin0 0->9 borrows; bin1 0->5 borrows; bin2 0->9 borrows;
//         bin3 decrements. Result 00:00 -> ALARM on that same tick edge.
//  ALARM: alarm=1, digits stay 00:00. start, stop or clear -> IDLE next cycle.
//  Load sanitising: set0/set2/set3 >9 load as 9; set1 >5 loads as 5.
//  Max time 99:59; no wrap below 00:00.
//  Reset mid-operation: asynchronous return to reset values, regardless of state.
// CONFIGURATION
//  ALARM_TIMEOUT_EN defined: in ALARM the prescaler keeps running. After
//    ALARM_SECS ticks the block enters IDLE automatically, alarm=0.
//    Start/stop/clear still acknowledge early.
//  Not defined: alarm is held until start, stop or clear. No timeout logic.
// TESTING (TICK_DIV=4, ALARM_SECS=3)
//  1 reset mid-RUN at 01:30 -> all outputs 0 immediately, state IDLE
//  2 load 01:00, start -> after 4 cycles 00:59 (bin1=5, bin0=9); 8 cycles 00:58
//  3 load 00:02, start -> 00:01, then 00:00 with alarm=1, running=0;
//    stop -> alarm=0, IDLE
//  4 RUN 00:10, stop 2 cycles into tick, hold 20 cycles -> no change;
//    start -> 00:09 after 2 more cycles
//  5 load set=F,7,C,A -> 99:59; same-cycle clear+start while RUN -> IDLE 00:00
//  6 ALARM_TIMEOUT_EN: alarm at 00:00 -> alarm drops after 12 cycles, IDLE;
//    without macro -> alarm still 1 after 100 cycles

Source files
------------

// File: rtl/timer_countdown.sv
// BCD MM:SS countdown core: loads a set time, decrements once per prescaled
// second and raises an alarm at 00:00. bin0..bin3 feed the digit scanner.
// Optional feature macro: ALARM_TIMEOUT_EN (alarm self-clears after
// ALARM_SECS ticks; without it the alarm holds until start/stop/clear).
module timer_countdown #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] set0,
  input  logic [3:0] set1,
  input  logic [3:0] set2,
  input  logic [3:0] set3,
  output logic [3:0] bin0,
  output logic [3:0] bin1,
  output logic [3:0] bin2,
  output logic [3:0] bin3,
  output logic       running,
  output logic       alarm
);

  if (TICK_DIV < 2 || ALARM_SECS < 1) begin : g_param_chk
    $error("timer_countdown: need TICK_DIV >= 2 and ALARM_SECS >= 1");
  end

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [3:0][3:0] dig_set, dig_dec;
  logic            tick;
  logic            at_zero;

`ifdef ALARM_TIMEOUT_EN
  localparam int unsigned ACW = $clog2(ALARM_SECS + 1);
  logic [ACW-1:0]  acnt_q, acnt_d;
`endif

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign at_zero = (dig_q == '0);

  // Clamp out-of-range BCD set digits to the largest legal value per position
  always_comb begin
    dig_set[0] = (set0 > 4'd9) ? 4'd9 : set0;
    dig_set[1] = (set1 > 4'd5) ? 4'd5 : set1;
    dig_set[2] = (set2 > 4'd9) ? 4'd9 : set2;
    dig_set[3] = (set3 > 4'd9) ? 4'd9 : set3;
  end

  // One-second decrement with BCD borrow chain (only used while time != 0)
  always_comb begin
    dig_dec = dig_q;
    if (dig_q[0] != 4'd0) begin
      dig_dec[0] = dig_q[0] - 4'd1;
    end else begin
      dig_dec[0] = 4'd9;
      if (dig_q[1] != 4'd0) begin
        dig_dec[1] = dig_q[1] - 4'd1;
      end else begin
        dig_dec[1] = 4'd5;
        if (dig_q[2] != 4'd0) begin
          dig_dec[2] = dig_q[2] - 4'd1;
        end else begin
          dig_dec[2] = 4'd9;
          dig_dec[3] = dig_q[3] - 4'd1;
        end
      end
    end
  end

  // Next-state logic: clear beats everything, then load, stop, start
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dig_d   = dig_q;
`ifdef ALARM_TIMEOUT_EN
    acnt_d  = (state_q == ALARM) ? acnt_q : '0;
`endif
    if (clear) begin
      state_d = IDLE;
      dig_d   = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            dig_d = dig_set;
          end else if (!stop && start && !at_zero) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          // An ignored load must not stall the timebase, so only stop pauses.
          if (stop && !load) begin
            state_d = PAUSE;
          end else if (tick) begin
            presc_d = '0;
            dig_d   = dig_dec;
            if (dig_dec == '0) state_d = ALARM;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start && !stop && !load) state_d = RUN;
        end
        ALARM: begin
          if (start || stop) begin
            state_d = IDLE;
            presc_d = '0;
          end else begin
`ifdef ALARM_TIMEOUT_EN
            if (tick) begin
              presc_d = '0;
              if (acnt_q == ACW'(ALARM_SECS - 1)) begin
                state_d = IDLE;
                acnt_d  = '0;
              end else begin
                acnt_d  = acnt_q + ACW'(1);
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
`else
            presc_d = presc_q;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, prescaler and digit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dig_q   <= dig_d;
    end
  end

`ifdef ALARM_TIMEOUT_EN
  // Alarm duration counter, in ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acnt_q <= '0;
    else        acnt_q <= acnt_d;
  end
`endif

  assign bin0    = dig_q[0];
  assign bin1    = dig_q[1];
  assign bin2    = dig_q[2];
  assign bin3    = dig_q[3];
  assign running = (state_q == RUN);
  assign alarm   = (state_q == ALARM);

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: seconds-based reference model checked every
// cycle, plus hand-computed literal checkpoints.
module tb_timer_countdown;
  localparam int TD = 4;
  localparam int AS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] set0 = '0, set1 = '0, set2 = '0, set3 = '0;
  logic [3:0] bin0, bin1, bin2, bin3;
  logic       running, alarm;

  int tests = 0;
  int fails = 0;

  timer_countdown #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .start(start), .stop(stop),
    .clear(clear), .set0(set0), .set1(set1), .set2(set2), .set3(set3),
    .bin0(bin0), .bin1(bin1), .bin2(bin2), .bin3(bin3),
    .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time in whole seconds, mode 0 idle/1 run/2 pause/3 alarm
  int m_mode = 0, m_secs = 0, m_ph = 0, m_acyc = 0;

  function automatic int sat(input logic [3:0] v, input int mx);
    return (int'(v) > mx) ? mx : int'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_secs = 0; m_ph = 0; m_acyc = 0;
    end else if (clear) begin
      m_mode = 0; m_secs = 0; m_ph = 0;
    end else begin
      case (m_mode)
        0: if (load)
             m_secs = sat(set3, 9) * 600 + sat(set2, 9) * 60 + sat(set1, 5) * 10 + sat(set0, 9);
           else if (!stop && start && m_secs != 0) begin m_mode = 1; m_ph = 0; end
        1: if (stop && !load) m_mode = 2;
           else begin
             m_ph++;
             if (m_ph == TD) begin
               m_ph = 0; m_secs--;
               if (m_secs == 0) begin m_mode = 3; m_acyc = 0; end
             end
           end
        2: if (start && !stop && !load) m_mode = 1;
        default: if (start || stop) begin m_mode = 0; m_ph = 0; end
`ifdef ALARM_TIMEOUT_EN
                 else begin
                   m_acyc++;
                   if (m_acyc == TD * AS) begin m_mode = 0; m_ph = 0; end
                 end
`endif
      endcase
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [17:0] got, exp;
    int ss, mm;
    ss  = m_secs % 60;
    mm  = m_secs / 60;
    exp = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_mode == 1, m_mode == 3};
    got = {bin3, bin2, bin1, bin0, running, alarm};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL model t=%0t got=%h expected=%h", $time, got, exp);
    end
  end

  task automatic chk(input string nm, input logic [3:0] e3, e2, e1, e0,
                     input logic er, input logic ea);
    logic [17:0] got, exp;
    got = {bin3, bin2, bin1, bin0, running, alarm};
    exp = {e3, e2, e1, e0, er, ea};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input logic l, input logic st, input logic sp, input logic cl);
    load = l; start = st; stop = sp; clear = cl;
    @(negedge clk);
    load = 0; start = 0; stop = 0; clear = 0;
  endtask

  task automatic load_time(input logic [3:0] s3, s2, s1, s0);
    set3 = s3; set2 = s2; set1 = s1; set0 = s0;
    cmd(1, 0, 0, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    chk("reset_state", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1);

    // start at 00:00 is ignored
    cmd(0, 1, 0, 0);
    step(2);
    chk("start_at_zero", 0, 0, 0, 0, 0, 0);

    // reset in the middle of RUN
    load_time(0, 1, 3, 0);
    cmd(0, 1, 0, 0);
    step(2);
    chk("run_0130", 0, 1, 3, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // first tick latency and minute borrow
    load_time(0, 1, 0, 0);
    chk("load_0100", 0, 1, 0, 0, 0, 0);
    cmd(0, 1, 0, 0);
    step(3);
    chk("pre_tick", 0, 1, 0, 0, 1, 0);
    step(1);
    chk("tick1_0059", 0, 0, 5, 9, 1, 0);
    step(4);
    chk("tick2_0058", 0, 0, 5, 8, 1, 0);
    cmd(0, 0, 0, 1);
    chk("clear_run", 0, 0, 0, 0, 0, 0);

    // tens-of-minutes borrow
    load_time(1, 0, 0, 0);
    cmd(0, 1, 0, 0);
    step(4);
    chk("borrow_0959", 0, 9, 5, 9, 1, 0);
    cmd(0, 0, 0, 1);

    // reach alarm, acknowledge with stop
    load_time(0, 0, 0, 2);
    cmd(0, 1, 0, 0);
    step(4);
    chk("tick_0001", 0, 0, 0, 1, 1, 0);
    step(4);
    chk("alarm_0000", 0, 0, 0, 0, 0, 1);
    cmd(0, 0, 1, 0);
    chk("alarm_ack", 0, 0, 0, 0, 0, 0);

    // pause two cycles into a second; prescaler holds
    load_time(0, 0, 1, 0);
    cmd(0, 1, 0, 0);
    step(2);
    cmd(0, 0, 1, 0);
    chk("paused", 0, 0, 1, 0, 0, 0);
    set3 = 4'd5; set0 = 4'd5;
    cmd(1, 0, 0, 0);
    step(19);
    chk("pause_hold", 0, 0, 1, 0, 0, 0);
    cmd(0, 1, 0, 0);
    chk("resume", 0, 0, 1, 0, 1, 0);
    step(1);
    chk("resume_1", 0, 0, 1, 0, 1, 0);
    step(1);
    chk("resume_0009", 0, 0, 0, 9, 1, 0);
    cmd(0, 0, 0, 1);

    // sanitised load, then clear+start together while running
    load_time(4'hA, 4'hC, 4'h7, 4'hF);
    chk("sanitise_9959", 9, 9, 5, 9, 0, 0);
    cmd(0, 1, 0, 0);
    step(2);
    cmd(0, 1, 0, 1);
    chk("clear_start", 0, 0, 0, 0, 0, 0);

    // alarm hold / timeout
    load_time(0, 0, 0, 1);
    cmd(0, 1, 0, 0);
    step(4);
    chk("alarm_enter", 0, 0, 0, 0, 0, 1);
`ifdef ALARM_TIMEOUT_EN
    step(11);
    chk("alarm_before_to", 0, 0, 0, 0, 0, 1);
    step(1);
    chk("alarm_timeout", 0, 0, 0, 0, 0, 0);
`else
    step(100);
    chk("alarm_held", 0, 0, 0, 0, 0, 1);
    cmd(0, 0, 0, 1);
    chk("alarm_clear", 0, 0, 0, 0, 0, 0);
`endif
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
